// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline: data-memory access over req/ready with a
// bounded wait, branch resolution, and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_mem_to_reg,
  input  logic                     in_reg_write,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     in_branch,
  input  logic                     in_is_equal,
  input  logic [ADDR_WIDTH-1:0]    in_pc_out,
  input  logic [DATA_WIDTH-1:0]    in_alu_out,
  input  logic [DATA_WIDTH-1:0]    in_store_data,
  input  logic [REG_NUM_WIDTH-1:0] in_rf_wr_num,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ready,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     stall,
  output logic                     branch_taken,
  output logic [ADDR_WIDTH-1:0]    branch_target,
  output logic                     dmem_err,
  output logic                     wb_mem_to_reg,
  output logic                     wb_reg_write,
  output logic [DATA_WIDTH-1:0]    wb_read_data,
  output logic [DATA_WIDTH-1:0]    wb_alu_out,
  output logic [REG_NUM_WIDTH-1:0] wb_rf_wr_num
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             memop;
  logic             isLoad;
  logic             accessing;
  logic             complete;
  logic             timeoutHit;
  logic             loadWb;

  always_comb begin
    memop      = in_mem_read | in_mem_write;
    isLoad     = in_mem_read & ~in_mem_write;
    accessing  = (state == ACCESS);
    complete   = accessing & dmem_ready;
    timeoutHit = accessing & ~dmem_ready & (cnt == CNT_LAST);
    // Anything that is neither a clean pass-through nor a completion is a bubble.
    loadWb     = ((state == IDLE) & ~memop) | complete;
  end

  always_comb begin
    dmem_req      = accessing;
    dmem_we       = in_mem_write;
    dmem_addr     = in_alu_out;
    dmem_wdata    = in_store_data;
    // Gated by rst so the front of the pipe is released the moment reset hits.
    stall         = rst & (((state == IDLE) & memop) | (accessing & ~dmem_ready & ~timeoutHit));
    branch_taken  = in_branch & in_is_equal & ~stall;
    branch_target = in_pc_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dmem_err      <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_out    <= '0;
      wb_rf_wr_num  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            state <= ACCESS;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            dmem_err <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (loadWb) begin
        wb_mem_to_reg <= in_mem_to_reg;
        wb_reg_write  <= in_reg_write;
        wb_alu_out    <= in_alu_out;
        wb_rf_wr_num  <= in_rf_wr_num;
        if (complete && isLoad) wb_read_data <= dmem_rdata;
      end else begin
        wb_mem_to_reg <= 1'b0;
        wb_reg_write  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instructions against a per-instruction timeline model.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_mem_to_reg, in_reg_write, in_mem_read, in_mem_write;
  logic          in_branch, in_is_equal;
  logic [AW-1:0] in_pc_out;
  logic [DW-1:0] in_alu_out, in_store_data;
  logic [RW-1:0] in_rf_wr_num;
  logic          dmem_req, dmem_we, dmem_ready;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          stall, branch_taken, dmem_err;
  logic [AW-1:0] branch_target;
  logic          wb_mem_to_reg, wb_reg_write;
  logic [DW-1:0] wb_read_data, wb_alu_out;
  logic [RW-1:0] wb_rf_wr_num;

  int errors = 0;
  int checks = 0;

  // Expected MEM/WB contents and error flag.
  logic          mM2R, mRW, mErr;
  logic [DW-1:0] mRead, mAlu;
  logic [RW-1:0] mRd;

  mem_access_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_branch(in_branch), .in_is_equal(in_is_equal),
    .in_pc_out(in_pc_out), .in_alu_out(in_alu_out),
    .in_store_data(in_store_data), .in_rf_wr_num(in_rf_wr_num),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_err(dmem_err),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_read_data(wb_read_data), .wb_alu_out(wb_alu_out),
    .wb_rf_wr_num(wb_rf_wr_num)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chkWb();
    chk("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(mM2R));
    chk("wb_reg_write",  64'(wb_reg_write),  64'(mRW));
    chk("wb_read_data",  64'(wb_read_data),  64'(mRead));
    chk("wb_alu_out",    64'(wb_alu_out),    64'(mAlu));
    chk("wb_rf_wr_num",  64'(wb_rf_wr_num),  64'(mRd));
    chk("dmem_err",      64'(dmem_err),      64'(mErr));
  endtask

  task automatic modelReset();
    mM2R = 1'b0; mRW = 1'b0; mErr = 1'b0; mRead = '0; mAlu = '0; mRd = '0;
  endtask

  // One instruction held in EX/MEM. A memop spends one IDLE cycle then
  // ACCESS cycles until ready arrives on access cycle 'lat' or TO expires.
  task automatic runInstr(input logic m2r, input logic rw, input logic rd, input logic wr,
                          input logic br, input logic eq, input logic [AW-1:0] pc,
                          input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                          input logic [RW-1:0] num, input int lat, input logic [DW-1:0] rdata);
    bit isMem  = rd | wr;
    bit isLoad = rd & ~wr;
    int last   = isMem ? ((lat < TO) ? lat : TO) : 0;
    bit expStall;
    in_mem_to_reg = m2r; in_reg_write = rw; in_mem_read = rd; in_mem_write = wr;
    in_branch = br; in_is_equal = eq; in_pc_out = pc; in_alu_out = alu;
    in_store_data = sd; in_rf_wr_num = num;
    for (int k = 0; k <= last; k++) begin
      dmem_ready = (k == 0) ? 1'($urandom_range(0, 1)) : (k == lat);
      dmem_rdata = (k == lat) ? rdata : $urandom;
      #1;
      expStall = isMem && (k < last);
      chk("stall",    64'(stall),    64'(expStall));
      chk("dmem_req", 64'(dmem_req), 64'(isMem && k >= 1));
      if (isMem && k >= 1) begin
        chk("dmem_we",    64'(dmem_we),    64'(wr));
        chk("dmem_addr",  64'(dmem_addr),  64'(alu));
        chk("dmem_wdata", 64'(dmem_wdata), 64'(sd));
      end
      chk("branch_taken",  64'(branch_taken),  64'(br & eq & ~expStall));
      chk("branch_target", 64'(branch_target), 64'(pc));
      chkWb();
      @(posedge clk);
      if (!isMem || k == lat) begin
        mM2R = m2r; mRW = rw; mAlu = alu; mRd = num;
        if (isMem && isLoad) mRead = rdata;
      end else begin
        mM2R = 1'b0; mRW = 1'b0;
        if (k == TO) mErr = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_mem_to_reg = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
    in_branch = 0; in_is_equal = 0; in_pc_out = '0; in_alu_out = '0;
    in_store_data = '0; in_rf_wr_num = '0; dmem_ready = 0; dmem_rdata = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req",   64'(dmem_req), 64'(0));
    chk("reset_stall", 64'(stall),    64'(0));
    chkWb();
    @(negedge clk);
    rst = 1'b1;

    // ALU op, load with 3-cycle memory, store ready at once, timeout, branches
    runInstr(0, 1, 0, 0, 0, 0, 32'h0, 32'h1234, 32'h0, 5'd7, 1, 32'h0);
    runInstr(1, 1, 1, 0, 0, 0, 32'h0, 32'h40, 32'h0, 5'd3, 3, 32'hDEADBEEF);
    runInstr(0, 0, 0, 1, 0, 0, 32'h0, 32'h100, 32'hA5A5, 5'd0, 1, 32'h0);
    runInstr(1, 1, 1, 0, 0, 0, 32'h0, 32'h44, 32'h0, 5'd9, TO + 5, 32'h0);
    runInstr(0, 0, 0, 0, 1, 1, 32'h80, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    runInstr(0, 0, 0, 0, 1, 0, 32'h80, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    runInstr(1, 1, 1, 1, 1, 1, 32'h90, 32'h48, 32'h77, 5'd4, 2, 32'h12345678);

    // Reset arriving in the second ACCESS cycle of a load
    in_mem_to_reg = 1; in_reg_write = 1; in_mem_read = 1; in_mem_write = 0;
    in_alu_out = 32'h200; in_rf_wr_num = 5'd11; dmem_ready = 0;
    #1; chk("mid_idle_stall", 64'(stall), 64'(1));
    @(posedge clk); mM2R = 0; mRW = 0; @(negedge clk);
    #1; chk("mid_acc1_req", 64'(dmem_req), 64'(1));
    @(posedge clk); mM2R = 0; mRW = 0; @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    chk("mid_rst_req",   64'(dmem_req), 64'(0));
    chk("mid_rst_stall", 64'(stall),    64'(0));
    chkWb();
    repeat (2) @(negedge clk);
    in_mem_read = 0; in_mem_to_reg = 0; in_reg_write = 0;
    rst = 1'b1;
    runInstr(1, 1, 1, 0, 0, 0, 32'h0, 32'h300, 32'h0, 5'd12, 2, 32'hCAFEF00D);

    for (int n = 0; n < 80; n++) begin
      int typ = $urandom_range(0, 4);
      runInstr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               typ == 1 || typ == 3, typ == 2 || typ == 3,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
               $urandom_range(1, TO + 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
